// File: rtl/std_add_pipe.sv
// Unsigned adder with a constant offset feeding a STAGES-deep elastic register
// pipeline; wrap or saturate on overflow, with an overflow flag riding along.
module std_add_pipe #(
  parameter int              WIDTH    = 32,
  parameter int              STAGES   = 2,
  parameter longint unsigned OFFSET   = 0,
  parameter int              SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int SW = WIDTH + 2;
  localparam logic [WIDTH-1:0] OFF_W = WIDTH'(OFFSET);

  logic [SW-1:0]    sum_full;
  logic             sum_ovf;
  logic [WIDTH-1:0] sum_res;

  logic [STAGES-1:0]            vld;
  logic [STAGES-1:0]            ovf_q;
  logic [STAGES-1:0][WIDTH-1:0] data_q;
  logic [STAGES-1:0]            load;

  // Two guard bits hold the carry of left + right + OFFSET without loss.
  assign sum_full = SW'(left) + SW'(right) + SW'(OFF_W);
  assign sum_ovf  = |sum_full[SW-1:WIDTH];
  assign sum_res  = (SATURATE != 0 && sum_ovf) ? '1 : sum_full[WIDTH-1:0];

  // Handshake: a beat crosses a boundary on a rising edge where valid && ready
  // are both high. Valid never waits on ready; in_ready depends only on
  // out_ready and stage occupancy, never on in_valid.
  // A stage can load when any stage at or after it is empty, or the consumer
  // is taking the last stage this cycle (bubble collapsing).
  always_comb begin
    load = '0;
    for (int i = 0; i < STAGES; i++) begin
      load[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!vld[j]) load[i] = 1'b1;
      end
    end
  end

  // Data only moves with a valid beat, so out reads 0 after reset until the
  // first real result arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld    <= '0;
      ovf_q  <= '0;
      data_q <= '0;
    end else begin
      if (load[0]) begin
        vld[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= sum_res;
          ovf_q[0]  <= sum_ovf;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          vld[i] <= vld[i-1];
          if (vld[i-1]) begin
            data_q[i] <= data_q[i-1];
            ovf_q[i]  <= ovf_q[i-1];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out       = data_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];
  assign out_valid = vld[STAGES-1];
  assign busy      = |vld;

endmodule

// File: tb/tb_std_add_pipe.sv
// Bench for std_add_pipe: WIDTH=32, STAGES=3, OFFSET=7, one wrapping and one
// saturating instance driven by the same stimulus.
module tb_std_add_pipe;
  localparam int W   = 32;
  localparam int ST  = 3;
  localparam int OFF = 7;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] left = '0;
  logic [W-1:0] right = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         in_ready_w, in_ready_s, out_valid_w, out_valid_s;
  logic         out_ovf_w, out_ovf_s, busy_w, busy_s;
  logic [W-1:0] out_w, out_s;

  int n_vec = 0;
  int n_fail = 0;

  // Expected entries: {ovf, wrapped result, saturated result}.
  logic [64:0] exp_q[$];
  int          cnt = 0;
  logic        hold_v = 1'b0;
  logic [64:0] hold_val = '0;

  always #5 clk = ~clk;

  std_add_pipe #(.WIDTH(W), .STAGES(ST), .OFFSET(OFF), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .in_valid(in_valid), .in_ready(in_ready_w), .out(out_w), .out_ovf(out_ovf_w),
    .out_valid(out_valid_w), .out_ready(out_ready), .busy(busy_w));

  std_add_pipe #(.WIDTH(W), .STAGES(ST), .OFFSET(OFF), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .left(left), .right(right),
    .in_valid(in_valid), .in_ready(in_ready_s), .out(out_s), .out_ovf(out_ovf_s),
    .out_valid(out_valid_s), .out_ready(out_ready), .busy(busy_s));

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] model(input logic [W-1:0] l, input logic [W-1:0] r);
    logic [W+1:0] s;
    logic         o;
    s = {2'b00, l} + {2'b00, r} + 34'(OFF);
    o = (s >= 34'h1_0000_0000);
    return {o, s[W-1:0], (o ? 32'hFFFF_FFFF : s[W-1:0])};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: inputs change just after posedge, so the negedge sees the
  // values that the coming edge will act on.
  always @(negedge clk) begin : monitor
    logic        acc, xfer;
    logic [64:0] e;
    if (!reset) begin
      exp_q.delete();
      cnt = 0;
      hold_v = 1'b0;
      check("rst_state", {out_valid_w, out_valid_s, busy_w, busy_s, out_w, out_s}, '0);
    end else begin
      check("in_ready", {in_ready_s, in_ready_w}, ((cnt < ST) || out_ready) ? 2'b11 : 2'b00);
      check("busy", {busy_s, busy_w}, (cnt > 0) ? 2'b11 : 2'b00);
      if (hold_v)
        check("stall_hold", {out_valid_w, out_valid_s, out_ovf_w, out_w, out_s}, {2'b11, hold_val});
      xfer = out_valid_w && out_ready;
      acc  = in_valid && in_ready_w;
      if (xfer) begin
        check("out_has_expect", (exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_data", {out_ovf_s, out_ovf_w, out_w, out_s}, {e[64], e});
        end
      end
      if (acc) exp_q.push_back(model(left, right));
      cnt = cnt + int'(acc) - int'(xfer);
      hold_v = out_valid_w && !out_ready;
      hold_val = {out_ovf_w, out_w, out_s};
    end
  end

  // One input on an idle pipe with out_ready high; result due after 3 edges.
  task automatic single(input logic [W-1:0] l, input logic [W-1:0] r,
                        input logic [W-1:0] w_exp, input logic [W-1:0] s_exp, input logic o_exp);
    left = l; right = r; in_valid = 1'b1;
    step();
    in_valid = 1'b0; left = $urandom; right = $urandom;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("lat_valid", out_valid_w, (k == 2));
      check("lat_busy", busy_w, (k < 3));
      if (k == 2) check("lat_result", {out_ovf_w, out_ovf_s, out_w, out_s}, {o_exp, o_exp, w_exp, s_exp});
      step();
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : driver
    int acc;
    int got;
    check("model_pin_a", model(32'd5, 32'd10), {1'b0, 32'd22, 32'd22});
    check("model_pin_b", model(32'hFFFF_FFFF, 32'd1), {1'b1, 32'h7, 32'hFFFF_FFFF});
    check("model_pin_c", model(32'hFFFF_FFF8, 32'd0), {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF});

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {in_ready_w, in_ready_s}, 2'b11);
    check("post_rst_out", {out_valid_w, out_w}, '0);
    step();

    single(32'd5, 32'd10, 32'd22, 32'd22, 1'b0);
    single(32'hFFFF_FFFF, 32'd1, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    single(32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    single(32'hFFFF_FFF9, 32'd0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    single(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1);
    single(32'd0, 32'd0, 32'd7, 32'd7, 1'b0);

    // Back-to-back stream, consumer always ready.
    got = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 10) begin left = c; right = 100; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clk);
      if (c < 10) check("stream_in_ready", in_ready_w, 1);
      if (out_valid_w) begin
        check("stream_out", out_w, 107 + got);
        got++;
      end else if (got > 0 && got < 10) begin
        check("stream_gap", out_valid_w, 1);
      end
      step();
    end
    check("stream_count", got, 10);

    // Consumer stalled: exactly three accepted, first result held.
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      left = acc; right = 200; in_valid = 1'b1;
      @(negedge clk);
      check("fill_in_ready", in_ready_w, (c < 3));
      if (in_ready_w) acc++;
      if (out_valid_w) check("fill_hold_out", out_w, 207);
      step();
    end
    check("fill_accepted", acc, 3);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drain_out", {out_valid_w, out_w}, {1'b1, 32'(207 + k)});
      step();
    end
    @(negedge clk);
    check("drain_empty", {out_valid_w, busy_w}, 2'b00);
    step();

    // Random valid/ready toggling; the compare process does the checking.
    acc = 0;
    for (int c = 0; c < 20000 && acc < 1000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      left = $urandom; right = $urandom;
      @(negedge clk);
      if (in_valid && in_ready_w) acc++;
      step();
    end
    check("rand_accepted", acc, 1000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (ST + 2) step();
    @(negedge clk);
    check("rand_drained", {32'(exp_q.size()), busy_w, busy_s}, '0);
    step();

    // Reset with a full pipe discards everything.
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      left = c; right = 50; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_full", {out_valid_w, busy_w, in_ready_w}, 3'b110);
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_clear", {out_valid_w, out_valid_s, busy_w, busy_s, out_w, out_s}, '0);
    step();
    reset = 1'b1; out_ready = 1'b1;
    left = 32'd1; right = 32'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("after_rst_valid", out_valid_w, (k == 2));
      if (k < 3) check("after_rst_out", out_w, (k == 2) ? 32'd9 : 32'd0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
